sym_freq_store: RTL and testbench
=================================

SYM_FREQ_STORE -- requirements
Module: sym_freq_store

Interface
REQ-001 SHALL have parameter SYM_W, default 4: symbol width in bits.
REQ-002 SHALL have parameter NSYM, default 10: number of histogram bins, at most 2^SYM_W.
REQ-003 SHALL have parameter DEPTH, default 256: maximum frame length in symbols.
REQ-004 SHALL have derived widths CNT_W = clog2(DEPTH+1) and AW = clog2(DEPTH).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1: begin a new frame.
REQ-008 SHALL have port frame_len, input, CNT_W: frame length, sampled on an accepted start.
REQ-009 SHALL have ports in_valid (input, 1), in_data (input, SYM_W) and in_ready (output, 1): symbol handshake.
REQ-010 SHALL have ports rd_addr (input, AW) and rd_data (output, SYM_W): buffer read port.
REQ-011 SHALL have port cnt_flat, output, NSYM*CNT_W: registered bin counts; bin k occupies bits [k*CNT_W +: CNT_W].
REQ-012 SHALL have port sym_count, output, CNT_W: number of symbols accepted in the current frame.
REQ-013 SHALL have output ports of width 1: busy, done (level), done_pulse and err_oor (sticky).

Function
REQ-014 SHALL implement a state machine IDLE -> COLLECT -> DONE, with DONE -> COLLECT on start.
REQ-015 SHALL leave IDLE or DONE only on start=1, with this action:
- clear all bins, sym_count and err_oor;
- latch eff_len = frame_len, or DEPTH when frame_len is 0 or greater than DEPTH;
- enter COLLECT on the next cycle.
REQ-016 SHALL ignore start while in COLLECT.
REQ-017 SHALL drive in_ready=1 only in COLLECT; a symbol is accepted when in_valid and in_ready are both 1.
REQ-018 SHALL, on each accepted symbol:
- write in_data to buffer[sym_count];
- increment bin[in_data];
- increment sym_count.
REQ-019 SHALL count a symbol with value >= NSYM in bin NSYM-1 and set err_oor, which stays set until the next start or rst.
REQ-020 SHALL, when an accepted symbol makes sym_count equal eff_len:
- move to DONE on the same edge;
- drive in_ready low on the following cycle;
- pulse done_pulse for exactly one cycle;
- hold done at 1 until the next start or rst.
REQ-021 SHALL present final counts on cnt_flat in the same cycle done first reads 1, with no extra latency.
REQ-022 SHALL hold bins below saturation; they cannot exceed eff_len by construction.
REQ-023 SHALL return buffer[rd_addr] on rd_data one cycle after rd_addr is presented.
REQ-024 SHALL accept reads in any state; addresses at or beyond sym_count return stale or undefined data.
REQ-025 SHALL, when a write and a read hit the same address in one cycle, return the old data.
REQ-026 SHALL drive busy = 1 exactly in COLLECT.
REQ-027 SHALL hold all outputs stable in DONE until start.

Reset
REQ-028 SHALL, on rst=1 at a clock edge:
- go to state IDLE;
- force all bins, sym_count, done, done_pulse, err_oor, busy and in_ready to 0;
- set rd_data to 0.
REQ-029 SHALL give rst priority over start and over an in-flight handshake.
REQ-030 SHALL abort a frame in progress on reset, discarding partial counts.
REQ-031 SHALL NOT clear buffer contents on reset.

Structure
REQ-032 SHALL put the state enum, the default parameter values and the clog2 helper function in the shared package sym_freq_pkg.
REQ-033 SHALL implement the buffer as sub-module sym_buf_ram: simple dual-port, one write port and one registered read port, DEPTH x SYM_W, inferable as block RAM.
REQ-034 SHALL keep the histogram as NSYM registers with a one-hot increment decoder, with no RAM read-modify-write.

Verification
REQ-035 SHALL cover full frame: default parameters, start with frame_len=0, 256 symbols i mod 10 with in_valid held high -> done after the 256th accept; bins 0-5 = 26, bins 6-9 = 25; done_pulse high for one cycle only.
REQ-036 SHALL cover short frame with backpressure: frame_len=5, symbols 3,3,7,0,3 with in_valid toggling every cycle -> bin3=3, bin7=1, bin0=1, sym_count=5; in_ready low after DONE; a sixth symbol is not counted.
REQ-037 SHALL cover out-of-range symbols: frame_len=4, symbols 12,15,2,9 -> bin9=3, bin2=1, err_oor=1; err_oor clears on the next start.
REQ-038 SHALL cover readback: after REQ-036, rd_addr 0..4 -> rd_data 3,3,7,0,3, each one cycle after its address; same-address write/read returns the old value.
REQ-039 SHALL cover reset mid-frame: rst asserted after 100 accepts of a 256-symbol frame -> next cycle state IDLE, all bins 0, busy 0, done 0; a following start with frame_len=3 and 3 symbols -> done with sym_count=3.
REQ-040 SHALL cover start priority: start held high throughout COLLECT -> no restart; start together with rst -> IDLE.

Source files
------------

// File: rtl/sym_freq_pkg.sv
// Shared types, default parameters and helpers for the symbol-frequency store.
package sym_freq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam int unsigned SYM_W_DEF = 4;
  localparam int unsigned NSYM_DEF  = 10;
  localparam int unsigned DEPTH_DEF = 256;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sym_buf_ram.sv
// Simple dual-port symbol buffer: one write port, one registered read port (read-before-write).
module sym_buf_ram #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sym_freq_store.sv
// Frame-based symbol histogram with a symbol buffer and registered bin counts.
module sym_freq_store
  import sym_freq_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF,
  parameter int unsigned NSYM  = NSYM_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned CNT_W = clog2(DEPTH + 1),
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  in_valid,
  input  logic [SYM_W-1:0]      in_data,
  output logic                  in_ready,
  input  logic [AW-1:0]         rd_addr,
  output logic [SYM_W-1:0]      rd_data,
  output logic [NSYM*CNT_W-1:0] cnt_flat,
  output logic [CNT_W-1:0]      sym_count,
  output logic                  busy,
  output logic                  done,
  output logic                  done_pulse,
  output logic                  err_oor
);

  localparam logic [SYM_W:0]   NSYM_EXT = (SYM_W + 1)'(NSYM);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  state_t state_q, state_d;

  logic [CNT_W-1:0] bins_q [NSYM];
  logic [CNT_W-1:0] bins_d [NSYM];
  logic [CNT_W-1:0] sym_count_q, sym_count_d;
  logic [CNT_W-1:0] eff_len_q, eff_len_d;
  logic             done_q, done_d;
  logic             done_pulse_q, done_pulse_d;
  logic             err_q, err_d;

  logic             accept, start_ok, oor, last;
  logic [SYM_W-1:0] bin_sel;
  logic [NSYM-1:0]  bin_hit;

  assign in_ready = (state_q == S_COLLECT);
  assign busy     = (state_q == S_COLLECT);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state_q != S_COLLECT);
  assign oor      = ({1'b0, in_data} >= NSYM_EXT);
  assign bin_sel  = oor ? SYM_W'(NSYM - 1) : in_data;
  assign last     = accept && ((sym_count_q + CNT_W'(1)) == eff_len_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_COLLECT;
      S_COLLECT:      if (last)     state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    for (int unsigned k = 0; k < NSYM; k++) begin
      bin_hit[k] = accept && (bin_sel == SYM_W'(k));
    end
  end

  always_comb begin
    bins_d       = bins_q;
    sym_count_d  = sym_count_q;
    eff_len_d    = eff_len_q;
    done_d       = done_q;
    done_pulse_d = 1'b0;
    err_d        = err_q;
    if (start_ok) begin
      bins_d      = '{default: '0};
      sym_count_d = '0;
      err_d       = 1'b0;
      done_d      = 1'b0;
      eff_len_d   = ((frame_len == '0) || (frame_len > DEPTH_C)) ? DEPTH_C : frame_len;
    end else if (accept) begin
      for (int unsigned k = 0; k < NSYM; k++) begin
        if (bin_hit[k]) bins_d[k] = bins_q[k] + CNT_W'(1);
      end
      sym_count_d = sym_count_q + CNT_W'(1);
      if (oor) err_d = 1'b1;
      if (last) begin
        done_d       = 1'b1;
        done_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bins_q       <= '{default: '0};
      sym_count_q  <= '0;
      eff_len_q    <= '0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bins_q       <= bins_d;
      sym_count_q  <= sym_count_d;
      eff_len_q    <= eff_len_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      err_q        <= err_d;
    end
  end

  for (genvar k = 0; k < NSYM; k++) begin : g_flat
    assign cnt_flat[k*CNT_W +: CNT_W] = bins_q[k];
  end

  assign sym_count  = sym_count_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign err_oor    = err_q;

  // Write address is the pre-increment count, always below eff_len <= DEPTH.
  sym_buf_ram #(
    .W     (SYM_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (accept),
    .waddr_i (sym_count_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_sym_freq_store.sv
// Scoreboard bench for sym_freq_store: frame results and buffer reads are checked by a monitor.
module tb_sym_freq_store;

  localparam int SYM_W = 4;
  localparam int NSYM  = 10;
  localparam int DEPTH = 256;
  localparam int CNT_W = 9;
  localparam int AW    = 8;

  logic                  clk = 1'b0;
  logic                  rst, start, in_valid, in_ready;
  logic [CNT_W-1:0]      frame_len;
  logic [SYM_W-1:0]      in_data, rd_data;
  logic [AW-1:0]         rd_addr;
  logic [NSYM*CNT_W-1:0] cnt_flat;
  logic [CNT_W-1:0]      sym_count;
  logic                  busy, done, done_pulse, err_oor;

  always #5 clk = ~clk;

  sym_freq_store #(
    .SYM_W (SYM_W),
    .NSYM  (NSYM),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_len  (frame_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cnt_flat   (cnt_flat),
    .sym_count  (sym_count),
    .busy       (busy),
    .done       (done),
    .done_pulse (done_pulse),
    .err_oor    (err_oor)
  );

  typedef struct {
    string            name;
    logic [89:0]      cnt;
    logic [CNT_W-1:0] sc;
    logic             err;
  } done_exp_t;

  int          checks = 0;
  int          errors = 0;
  done_exp_t   done_q[$];
  logic [3:0]  rd_q[$];
  done_exp_t   d_cur;
  logic [3:0]  rd_e;
  bit          rd_tag = 1'b0;
  bit          rd_seen = 1'b0;
  bit          prev_pulse = 1'b0;
  int          exp_b [10];
  logic [3:0]  short_syms [5];

  task automatic chk(input string name, input logic [89:0] act, input logic [89:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [89:0] pack(input int b [10]);
    logic [89:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[k*CNT_W +: CNT_W] = CNT_W'(b[k]);
    return r;
  endfunction

  task automatic expect_done(input string n, input logic [CNT_W-1:0] sc, input logic e);
    done_exp_t d;
    d.name = n;
    d.cnt  = pack(exp_b);
    d.sc   = sc;
    d.err  = e;
    done_q.push_back(d);
  endtask

  // Monitor: buffer reads and frame completions are popped from the scoreboard.
  always @(posedge clk) rd_seen <= rd_tag;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
      end else begin
        rd_e = rd_q.pop_front();
        chk("rd_data", rd_data, rd_e);
      end
    end
    if (prev_pulse) chk("done_pulse_width", done_pulse, 0);
    if (done_pulse) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        d_cur = done_q.pop_front();
        chk({d_cur.name, "_bins"},  cnt_flat,  d_cur.cnt);
        chk({d_cur.name, "_count"}, sym_count, d_cur.sc);
        chk({d_cur.name, "_err"},   err_oor,   d_cur.err);
        chk({d_cur.name, "_level"}, done,      1);
        chk({d_cur.name, "_ready"}, in_ready,  0);
      end
    end
    prev_pulse = done_pulse;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] len);
    start = 1'b1;
    frame_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] s, input bit gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = s;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready0 required=in_ready1");
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    repeat (3) tick();
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_pulse", done_pulse, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_err",   err_oor, 0);
    chk("rst_count", sym_count, 0);
    chk("rst_bins",  cnt_flat, 0);
    chk("rst_rd",    rd_data, 0);
    rst = 1'b0;
    tick();

    // Full 256-symbol frame with frame_len = 0.
    exp_b = '{26, 26, 26, 26, 26, 26, 25, 25, 25, 25};
    expect_done("full", 9'd256, 1'b0);
    do_start(9'd0);
    chk("full_busy", busy, 1);
    for (int i = 0; i < 256; i++) send(4'(i % 10), 1'b0);
    in_valid = 1'b0;
    chk("full_done_latency", done, 1);
    tick();
    chk("full_busy_after", busy, 0);

    // Short frame with valid toggling.
    short_syms = '{4'd3, 4'd3, 4'd7, 4'd0, 4'd3};
    exp_b = '{1, 0, 0, 3, 0, 0, 0, 1, 0, 0};
    expect_done("short", 9'd5, 1'b0);
    do_start(9'd5);
    for (int i = 0; i < 5; i++) send(short_syms[i], 1'b1);
    chk("short_done", done, 1);
    in_valid = 1'b1;
    in_data  = 4'd3;
    repeat (3) tick();
    chk("short_ready_low", in_ready, 0);
    chk("short_sixth_count", sym_count, 5);
    chk("short_sixth_bins", cnt_flat, pack(exp_b));
    chk("short_done_hold", done, 1);
    in_valid = 1'b0;

    for (int a = 0; a < 5; a++) begin
      rd_addr = AW'(a);
      rd_tag  = 1'b1;
      rd_q.push_back(short_syms[a]);
      tick();
    end
    rd_tag = 1'b0;
    tick();

    // Out-of-range symbols; first write collides with a read of address 0.
    exp_b = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 3};
    expect_done("oor", 9'd4, 1'b1);
    do_start(9'd4);
    rd_addr = '0;
    rd_tag  = 1'b1;
    rd_q.push_back(4'd3);
    send(4'd12, 1'b0);
    rd_tag = 1'b0;
    send(4'd15, 1'b0);
    send(4'd2, 1'b0);
    send(4'd9, 1'b0);
    in_valid = 1'b0;
    chk("oor_done", done, 1);
    chk("oor_err_sticky", err_oor, 1);
    rd_addr = '0;
    rd_tag  = 1'b1;
    rd_q.push_back(4'd12);
    tick();
    rd_tag = 1'b0;
    tick();

    // Restart clears err_oor, then reset aborts the frame after 100 accepts.
    do_start(9'd0);
    chk("restart_err_clear", err_oor, 0);
    chk("restart_count", sym_count, 0);
    chk("restart_bins", cnt_flat, 0);
    for (int i = 0; i < 100; i++) send(4'(i % 10), 1'b0);
    chk("abort_pre_count", sym_count, 100);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    chk("abort_busy",  busy, 0);
    chk("abort_done",  done, 0);
    chk("abort_bins",  cnt_flat, 0);
    chk("abort_count", sym_count, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_pulse", done_pulse, 0);
    chk("abort_rd",    rd_data, 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();
    chk("abort_idle", busy, 0);

    exp_b = '{0, 2, 0, 0, 1, 0, 0, 0, 0, 0};
    expect_done("post_rst", 9'd3, 1'b0);
    do_start(9'd3);
    send(4'd1, 1'b0);
    send(4'd1, 1'b0);
    send(4'd4, 1'b0);
    in_valid = 1'b0;
    chk("post_rst_done", done, 1);
    tick();

    // Start held high through COLLECT must not restart the frame.
    exp_b = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    expect_done("held", 9'd6, 1'b0);
    start = 1'b1;
    frame_len = 9'd6;
    tick();
    for (int i = 0; i < 6; i++) send(4'(i), 1'b0);
    start = 1'b0;
    in_valid = 1'b0;
    chk("held_done", done, 1);
    tick();
    chk("held_still_done", done, 1);
    chk("held_count", sym_count, 6);

    repeat (3) tick();
    chk("done_queue_empty", done_q.size(), 0);
    chk("rd_queue_empty", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
